// File: rtl/backbone_sweep_ctrl.sv
// Sweep initiator for the backbone-product engine. The controller issues one request per excluded
// index and gathers each 32-bit leave-one-out response into a J-slot result vector.
module backbone_sweep_ctrl #(
    parameter int J       = 14,
    parameter int A       = 2,
    parameter int TIMEOUT = 64,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [J*A*8-1:0]     alpha_u_in,
    input  logic [J*A_WIDTH-1:0] x_initial_in,
    output logic [J*A*8-1:0]     alpha_u,
    output logic [J*A_WIDTH-1:0] x_initial,
    output logic [J_WIDTH-1:0]   ind_j,
    output logic                 din_tvalid,
    input  logic                 backbone_initial_tvalid,
    input  logic [31:0]          backbone_initial,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [J*32-1:0]      backbone_all
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [J_WIDTH-1:0]     r_ind_j;
    logic [J_WIDTH-1:0]     w_ind_nxt;
    logic [CNT_WIDTH-1:0]   r_wait_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   w_latch;
    logic                   w_slot_we;
    logic [31:0]            w_slot_data;
    logic                   r_din_tvalid;
    logic                   r_busy;
    logic                   r_done;
    logic [J*A*8-1:0]       r_alpha_u;
    logic [J*A_WIDTH-1:0]   r_x_initial;
    logic [J*32-1:0]        r_backbone_all;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, index advance, timeout detection and slot-write decode
    always_comb begin
        w_state_nxt = r_state;
        w_ind_nxt   = r_ind_j;
        w_cnt_nxt   = r_wait_cnt;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        w_slot_we   = 1'b0;
        w_slot_data = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_ind_nxt   = {J_WIDTH{1'b0}};
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = {CNT_WIDTH{1'b0}};
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_wait_cnt + CNT_WIDTH'(1);
                // A response on the final wait cycle beats the timeout.
                if (backbone_initial_tvalid) begin
                    w_slot_we   = 1'b1;
                    w_slot_data = backbone_initial;
                end else if (r_wait_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                    w_slot_we   = 1'b1;
                    w_slot_data = 32'd0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_slot_we   = 1'b0;
                end
                if (w_slot_we) begin
                    if (r_ind_j == J_WIDTH'(J - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ind_nxt   = r_ind_j + J_WIDTH'(1);
                        w_state_nxt = S_ISSUE;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers and registered strobes derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ind_j        <= {J_WIDTH{1'b0}};
            r_wait_cnt     <= {CNT_WIDTH{1'b0}};
            r_err          <= 1'b0;
            r_din_tvalid   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_alpha_u      <= {(J*A*8){1'b0}};
            r_x_initial    <= {(J*A_WIDTH){1'b0}};
            r_backbone_all <= {(J*32){1'b0}};
        end else begin
            r_ind_j      <= w_ind_nxt;
            r_wait_cnt   <= w_cnt_nxt;
            r_err        <= w_err_nxt;
            r_din_tvalid <= (w_state_nxt == S_ISSUE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            if (w_latch) begin
                r_alpha_u   <= alpha_u_in;
                r_x_initial <= x_initial_in;
            end
            if (w_slot_we) begin
                for (int k = 0; k < J; k++) begin
                    if (r_ind_j == J_WIDTH'(k)) begin
                        r_backbone_all[k*32 +: 32] <= w_slot_data;
                    end
                end
            end
        end
    end

    assign alpha_u      = r_alpha_u;
    assign x_initial    = r_x_initial;
    assign ind_j        = r_ind_j;
    assign din_tvalid   = r_din_tvalid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign backbone_all = r_backbone_all;

endmodule

// File: tb/tb_backbone_sweep_ctrl.sv
// Self-checking bench for backbone_sweep_ctrl: a latency-programmable responder, a table of sweep
// scenarios, randomized sweeps against a per-index reference model, and reset/back-to-back sequences.
module tb_backbone_sweep_ctrl;

    localparam int J       = 14;
    localparam int A       = 2;
    localparam int TIMEOUT = 64;
    localparam int JW      = $clog2(J) + 1;
    localparam int AWS     = $clog2(A) + 1;
    localparam int AW      = J * A * 8;
    localparam int XW      = J * AWS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   alpha_u_in;
    logic [XW-1:0]   x_initial_in;
    logic [AW-1:0]   alpha_u;
    logic [XW-1:0]   x_initial;
    logic [JW-1:0]   ind_j;
    logic            din_tvalid;
    logic            backbone_initial_tvalid;
    logic [31:0]     backbone_initial;
    logic            busy;
    logic            done;
    logic            err;
    logic [J*32-1:0] backbone_all;

    backbone_sweep_ctrl #(.J(J), .A(A), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .alpha_u_in              (alpha_u_in),
        .x_initial_in            (x_initial_in),
        .alpha_u                 (alpha_u),
        .x_initial               (x_initial),
        .ind_j                   (ind_j),
        .din_tvalid              (din_tvalid),
        .backbone_initial_tvalid (backbone_initial_tvalid),
        .backbone_initial        (backbone_initial),
        .busy                    (busy),
        .done                    (done),
        .err                     (err),
        .backbone_all            (backbone_all)
    );

    always #5 clk = ~clk;

    // Responder configuration: lat 0 means the response is dropped.
    int          lat[J];
    logic [31:0] rdata[J];

    typedef struct {
        int          due;
        logic [31:0] d;
    } ev_t;
    ev_t  evq[$];
    int   iss_q[$];
    int   t = 0;
    int   done_cnt = 0;
    int   done_tick = 0;

    // Reference model outputs
    logic [31:0] exp_slot[J];
    bit          exp_err;
    int          exp_delay;

    int total = 0;
    int bad = 0;
    int exp_done = 0;

    typedef struct {
        int base_lat;
        int sp_idx;
        int sp_lat;
        bit stray;
        bit e_err;
        int e_delay;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [AW-1:0] rand_alpha();
        logic [AW-1:0] v;
        v = '0;
        for (int i = 0; i < AW; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    // Per index: a response within TIMEOUT cycles is stored, otherwise the slot is zero after TIMEOUT.
    task automatic model();
        exp_delay = 1;
        exp_err   = 1'b0;
        for (int k = 0; k < J; k++) begin
            if (lat[k] >= 1 && lat[k] <= TIMEOUT) begin
                exp_slot[k] = rdata[k];
                exp_delay  += lat[k] + 1;
            end else begin
                exp_slot[k] = 32'd0;
                exp_err     = 1'b1;
                exp_delay  += TIMEOUT + 1;
            end
        end
    endtask

    // Monitor and engine responder, both on the falling edge.
    initial begin
        ev_t ev;
        backbone_initial_tvalid = 1'b0;
        backbone_initial        = 32'd0;
        forever begin
            @(negedge clk);
            t++;
            if (done) begin
                done_cnt++;
                done_tick = t;
            end
            backbone_initial_tvalid = 1'b0;
            backbone_initial        = $urandom;
            if (evq.size() > 0 && evq[0].due == t) begin
                backbone_initial_tvalid = 1'b1;
                backbone_initial        = evq[0].d;
                void'(evq.pop_front());
            end
            if (din_tvalid) begin
                iss_q.push_back(int'(ind_j));
                if (int'(ind_j) < J && lat[int'(ind_j)] > 0) begin
                    ev.due = t + lat[int'(ind_j)];
                    ev.d   = rdata[int'(ind_j)];
                    evq.push_back(ev);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ind_j"}, ind_j, 0);
        chk({tag, "_din_tvalid"}, din_tvalid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_backbone_all"}, backbone_all, 0);
        chk({tag, "_alpha_u"}, alpha_u, 0);
        chk({tag, "_x_initial"}, x_initial, 0);
    endtask

    task automatic launch(output int ts);
        iss_q.delete();
        @(negedge clk); #1;
        start = 1'b1;
        ts    = t;
        @(negedge clk); #1;
        start = 1'b0;
        chk("issue0_tvalid", din_tvalid, 1);
        chk("issue0_busy", busy, 1);
        chk("issue0_ind_j", ind_j, 0);
        chk("issue0_err_cleared", err, 0);
    endtask

    task automatic wait_and_check(input int ts, input bit stray, input int e_delay, input bit e_err,
                                  input logic [AW-1:0] e_alpha, input logic [XW-1:0] e_x);
        int n;
        int c0;
        n  = 0;
        c0 = done_cnt;
        while (done_cnt == c0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
            if (stray) begin
                start = (n == 25 || n == 90);
                if (start) alpha_u_in = rand_alpha();
            end
        end
        start = 1'b0;
        if (done_cnt == c0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_delay", done_tick - ts, e_delay);
            chk("iss_count", iss_q.size(), J);
            for (int k = 0; k < J && k < iss_q.size(); k++) chk($sformatf("iss_seq[%0d]", k), iss_q[k], k);
            for (int k = 0; k < J; k++) chk($sformatf("slot[%0d]", k), backbone_all[k*32 +: 32], exp_slot[k]);
            chk("err", err, e_err);
            chk("alpha_u", alpha_u, e_alpha);
            chk("x_initial", x_initial, e_x);
        end
    endtask

    task automatic post_done();
        @(negedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("done_count", done_cnt, exp_done);
    endtask

    initial begin
        int ts;
        int n;
        logic [AW-1:0] ea;
        logic [XW-1:0] ex;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ts;
        int n;
        logic [AW-1:0] ea;
        logic [XW-1:0] ex;

        tbl[0] = '{3, 0, 3, 1'b0, 1'b0, 57};    // nominal, L=3
        tbl[1] = '{3, 5, 0, 1'b0, 1'b1, 118};   // dropped response at index 5
        tbl[2] = '{3, 9, 64, 1'b0, 1'b0, 118};  // response on the last wait cycle
        tbl[3] = '{3, 5, 65, 1'b1, 1'b1, 118};  // late response lands in ISSUE of 6, stray starts
        tbl[4] = '{1, 13, 1, 1'b0, 1'b0, 29};   // minimum latency
        tbl[5] = '{2, 13, 0, 1'b0, 1'b1, 105};  // timeout on the final index

        rst          = 1'b1;
        start        = 1'b0;
        alpha_u_in   = rand_alpha();
        x_initial_in = XW'($urandom);
        for (int k = 0; k < J; k++) begin
            lat[k]   = 3;
            rdata[k] = 32'h1000_0000 + k;
        end
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < J; k++) begin
                lat[k]   = tbl[i].base_lat;
                rdata[k] = 32'h1000_0000 + k;
            end
            lat[tbl[i].sp_idx] = tbl[i].sp_lat;
            model();
            alpha_u_in   = rand_alpha();
            x_initial_in = XW'($urandom);
            ea = alpha_u_in;
            ex = x_initial_in;
            launch(ts);
            wait_and_check(ts, tbl[i].stray, tbl[i].e_delay, tbl[i].e_err, ea, ex);
            exp_done++;
            post_done();
        end

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < J; k++) begin
                rdata[k] = $urandom;
                lat[k]   = int'($urandom_range(1, 6));
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0: lat[k] = 0;
                        1: lat[k] = TIMEOUT;
                        2: lat[k] = TIMEOUT + 1;
                        default: lat[k] = 1;
                    endcase
                end
            end
            model();
            alpha_u_in   = rand_alpha();
            x_initial_in = XW'($urandom);
            ea = alpha_u_in;
            ex = x_initial_in;
            launch(ts);
            wait_and_check(ts, 1'b0, exp_delay, exp_err, ea, ex);
            exp_done++;
            post_done();
        end

        // Reset while index 7 is being issued; index 2 timed out earlier so err is set.
        for (int k = 0; k < J; k++) begin
            lat[k]   = 2;
            rdata[k] = $urandom;
        end
        lat[2] = 0;
        alpha_u_in = rand_alpha();
        launch(ts);
        n = 0;
        while (iss_q.size() < 8 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reached_index7", iss_q.size(), 8);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check_reset_vals("midreset");
        repeat (100) @(negedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, exp_done);

        // Clean sweep after the aborted one
        for (int k = 0; k < J; k++) begin
            lat[k]   = 3;
            rdata[k] = $urandom;
        end
        model();
        alpha_u_in   = rand_alpha();
        x_initial_in = XW'($urandom);
        ea = alpha_u_in;
        ex = x_initial_in;
        launch(ts);
        wait_and_check(ts, 1'b0, exp_delay, exp_err, ea, ex);
        exp_done++;

        // Back-to-back: start raised in the DONE cycle and held into the first IDLE cycle.
        alpha_u_in   = rand_alpha();
        x_initial_in = XW'($urandom);
        ea = alpha_u_in;
        ex = x_initial_in;
        for (int k = 0; k < J; k++) begin
            lat[k]   = int'($urandom_range(1, 4));
            rdata[k] = $urandom;
        end
        model();
        iss_q.delete();
        start = 1'b1;
        ts    = t + 1;
        @(negedge clk); #1;
        chk("b2b_idle_busy", busy, 0);
        @(negedge clk); #1;
        start = 1'b0;
        chk("b2b_issue_tvalid", din_tvalid, 1);
        chk("b2b_alpha_u", alpha_u, ea);
        wait_and_check(ts, 1'b0, exp_delay, exp_err, ea, ex);
        exp_done++;
        post_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
